// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD arbiter slice: LCD word format, the
// arbiter state encoding, requester index constants and a small helper.
package lcd_pkg;

    localparam int LCD_WORD_W = 9;

    // {rs, data[7:0]}, same layout as the ROM words
    typedef logic [LCD_WORD_W-1:0] lcd_word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOCKED,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } arb_state_t;

    localparam logic REQ_INIT = 1'b0;   // init/command sequencer
    localparam logic REQ_CALC = 1'b1;   // calculator display writer

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == REQ_CALC) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lcd_arbiter_if.sv
// Requester-side handshake bundle of the LCD arbiter.
//   req0/req1   : word request, held high until ack
//   data0/data1 : LCD word {rs, d[7:0]}, stable while req is high
//   last0/last1 : word closes the burst, stable while req is high
//   ack0/ack1   : one-cycle pulse, word consumed
// master = requester side, slave = arbiter side.
interface lcd_arbiter_if;
    import lcd_pkg::*;

    logic      req0;
    logic      req1;
    lcd_word_t data0;
    lcd_word_t data1;
    logic      last0;
    logic      last1;
    logic      ack0;
    logic      ack1;

    modport master (
        output req0, req1, data0, data1, last0, last1,
        input  ack0, ack1
    );

    modport slave (
        input  req0, req1, data0, data1, last0, last1,
        output ack0, ack1
    );

endinterface

// File: rtl/lcd_arbiter.sv
// Two-port arbiter in front of the single LCD writer. Port 0 is the
// init/command sequencer, port 1 the calculator display writer. Bursts
// (closed by the last flag) are never interleaved; issue is paced by the
// LCD busy flag, and a silent LCD or an idle lock owner is recovered by
// timeouts that set a sticky error flag.
// Ports:
//   clock, internal_reset : system clock, synchronous active-high reset
//   bus                   : requester handshake (lcd_arbiter_if.slave)
//   lcd_d_in              : word presented to the lcd
//   lcd_data_ready        : one-cycle issue strobe to the lcd
//   lcd_busy              : lcd busy flag
//   grant                 : one-hot current owner, 0 when free
//   timeout_err           : sticky timeout flag, cleared only by reset
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int BUSY_RISE_MAX = 16,
    parameter int LOCK_IDLE_MAX = 5000000,
    parameter int FIXED_PRIO    = 0
) (
    input  logic         clock,
    input  logic         internal_reset,
    lcd_arbiter_if.slave bus,
    output lcd_word_t    lcd_d_in,
    output logic         lcd_data_ready,
    input  logic         lcd_busy,
    output logic [1:0]   grant,
    output logic         timeout_err
);

    localparam int CNT_MAX = (BUSY_RISE_MAX > LOCK_IDLE_MAX) ? BUSY_RISE_MAX : LOCK_IDLE_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_RISE_MAX);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_IDLE_MAX);

    arb_state_t       state;
    logic             owner;
    logic             last_q;
    logic             rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic      winner;
    logic      owner_req;
    logic      take_port;
    logic      issue_go;
    lcd_word_t take_data;
    logic      take_last;

    // The IDLE grant and the LOCKED re-issue share one latch path: the
    // only difference is whether the port comes from arbitration or from
    // the current owner.
    always_comb begin
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

        winner = REQ_INIT;
        if (FIXED_PRIO != 0)
            winner = bus.req0 ? REQ_INIT : REQ_CALC;
        else if (bus.req0 && bus.req1)
            winner = rr_ptr;
        else if (bus.req1)
            winner = REQ_CALC;

        owner_req = (owner == REQ_CALC) ? bus.req1 : bus.req0;
        take_port = (state == IDLE) ? winner : owner;
        issue_go  = !lcd_busy &&
                    (((state == IDLE) && (bus.req0 || bus.req1)) ||
                     ((state == LOCKED) && owner_req));
        take_data = (take_port == REQ_CALC) ? bus.data1 : bus.data0;
        take_last = (take_port == REQ_CALC) ? bus.last1 : bus.last0;
    end

    always_ff @(posedge clock) begin
        if (internal_reset) begin
            state          <= IDLE;
            owner          <= REQ_INIT;
            last_q         <= 1'b0;
            rr_ptr         <= REQ_INIT;
            cnt            <= '0;
            lcd_d_in       <= '0;
            lcd_data_ready <= 1'b0;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            grant          <= '0;
            timeout_err    <= 1'b0;
        end else begin
            lcd_data_ready <= 1'b0;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            cnt            <= cnt_inc;

            if (issue_go) begin
                // strobe and ack are registered here so both appear in ISSUE
                owner          <= take_port;
                grant          <= port_onehot(take_port);
                lcd_d_in       <= take_data;
                last_q         <= take_last;
                lcd_data_ready <= 1'b1;
                bus.ack0       <= (take_port == REQ_INIT);
                bus.ack1       <= (take_port == REQ_CALC);
                state          <= ISSUE;
                cnt            <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    LOCKED: begin
                        if (cnt_inc == LOCK_LIM) begin
                            timeout_err <= 1'b1;
                            grant       <= '0;
                            rr_ptr      <= ~owner;
                            state       <= IDLE;
                            cnt         <= '0;
                        end
                    end
                    ISSUE: begin
                        state <= WAIT_HI;
                        cnt   <= '0;
                    end
                    WAIT_HI: begin
                        if (lcd_busy) begin
                            state <= WAIT_LO;
                            cnt   <= '0;
                        end else if (cnt_inc == BUSY_LIM) begin
                            timeout_err <= 1'b1;
                            grant       <= '0;
                            rr_ptr      <= ~owner;
                            state       <= IDLE;
                            cnt         <= '0;
                        end
                    end
                    WAIT_LO: begin
                        if (!lcd_busy) begin
                            if (last_q) begin
                                grant  <= '0;
                                rr_ptr <= ~owner;
                                state  <= IDLE;
                            end else begin
                                state <= LOCKED;
                            end
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Self-checking bench for lcd_arbiter: queue-driven requesters, a simple
// LCD busy model, an issue monitor, directed scenarios and randomized
// bursts checked against a burst-level round-robin predictor.
module tb_lcd_arbiter;
    import lcd_pkg::*;

    localparam int BUSY_MAX = 16;
    localparam int LOCK_MAX = 20;

    logic       clock = 1'b0;
    logic       internal_reset;
    lcd_word_t  lcd_d_in;
    logic       lcd_data_ready;
    logic       lcd_busy;
    logic [1:0] grant;
    logic       timeout_err;

    lcd_arbiter_if bus();

    lcd_arbiter #(
        .BUSY_RISE_MAX(BUSY_MAX),
        .LOCK_IDLE_MAX(LOCK_MAX),
        .FIXED_PRIO   (0)
    ) dut (
        .clock         (clock),
        .internal_reset(internal_reset),
        .bus           (bus),
        .lcd_d_in      (lcd_d_in),
        .lcd_data_ready(lcd_data_ready),
        .lcd_busy      (lcd_busy),
        .grant         (grant),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // requester word queues and presentation cycle of the current head word
    lcd_word_t wq0[$];
    lcd_word_t wq1[$];
    bit        lq0[$];
    bit        lq1[$];
    int        pres0 = 0;
    int        pres1 = 0;

    // issue log written by the monitor
    int        log_port[$];
    lcd_word_t log_word[$];
    int        log_cyc[$];

    // lcd model controls
    bit lcd_silent  = 1'b0;
    bit rand_lcd    = 1'b0;
    int rise_d      = 2;
    int busy_len    = 3;
    bit busy_active = 1'b0;
    int fall_cyc    = 0;
    int fall_count  = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // requester 0
    initial begin : drv0
        bit fresh;
        bus.req0  = 1'b0;
        bus.data0 = '0;
        bus.last0 = 1'b0;
        forever begin
            @(negedge clock);
            fresh = !bus.req0;
            if (bus.req0 && bus.ack0 && wq0.size() > 0) begin
                void'(wq0.pop_front());
                void'(lq0.pop_front());
                fresh = 1'b1;
            end
            if (wq0.size() > 0) begin
                bus.req0  = 1'b1;
                bus.data0 = wq0[0];
                bus.last0 = lq0[0];
                if (fresh) pres0 = cyc;
            end else begin
                bus.req0  = 1'b0;
                bus.last0 = 1'b0;
            end
        end
    end

    // requester 1
    initial begin : drv1
        bit fresh;
        bus.req1  = 1'b0;
        bus.data1 = '0;
        bus.last1 = 1'b0;
        forever begin
            @(negedge clock);
            fresh = !bus.req1;
            if (bus.req1 && bus.ack1 && wq1.size() > 0) begin
                void'(wq1.pop_front());
                void'(lq1.pop_front());
                fresh = 1'b1;
            end
            if (wq1.size() > 0) begin
                bus.req1  = 1'b1;
                bus.data1 = wq1[0];
                bus.last1 = lq1[0];
                if (fresh) pres1 = cyc;
            end else begin
                bus.req1  = 1'b0;
                bus.last1 = 1'b0;
            end
        end
    end

    // lcd: busy rises d cycles after the strobe and stays high l cycles
    initial begin : lcd_model
        int d;
        int l;
        lcd_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (lcd_data_ready && !lcd_silent) begin
                d = rand_lcd ? int'($urandom_range(1, 5)) : rise_d;
                l = rand_lcd ? int'($urandom_range(1, 5)) : busy_len;
                busy_active = 1'b1;
                repeat (d) @(negedge clock);
                lcd_busy = 1'b1;
                repeat (l) @(negedge clock);
                lcd_busy    = 1'b0;
                fall_cyc    = cyc;
                fall_count++;
                busy_active = 1'b0;
            end
        end
    end

    // issue monitor: ack only with the strobe and only to the owner;
    // word held while the lcd is busy
    initial begin : monitor
        bit        prev_busy = 1'b0;
        bit        prev_rst  = 1'b1;
        lcd_word_t prev_d    = '0;
        forever begin
            @(negedge clock);
            #1;
            if (!internal_reset && !prev_rst) begin
                if (lcd_data_ready) begin
                    checks++;
                    if (!((grant == 2'b01 && bus.ack0 && !bus.ack1) ||
                          (grant == 2'b10 && bus.ack1 && !bus.ack0))) begin
                        errors++;
                        $display("FAIL issue_ack: grant=%b ack0=%b ack1=%b, required one-hot grant with matching single ack",
                                 grant, bus.ack0, bus.ack1);
                    end
                    log_port.push_back(grant[1] ? 1 : 0);
                    log_word.push_back(lcd_d_in);
                    log_cyc.push_back(cyc);
                end else begin
                    checks++;
                    if (bus.ack0 || bus.ack1) begin
                        errors++;
                        $display("FAIL stray_ack: ack0=%b ack1=%b without data_ready, required 0 0", bus.ack0, bus.ack1);
                    end
                end
                if (lcd_busy && prev_busy) begin
                    checks++;
                    if (lcd_d_in !== prev_d) begin
                        errors++;
                        $display("FAIL data_hold: lcd_d_in=%h while busy, required %h", lcd_d_in, prev_d);
                    end
                end
            end
            prev_busy = lcd_busy;
            prev_d    = lcd_d_in;
            prev_rst  = internal_reset;
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) tick();
    endtask

    task automatic clear_log();
        log_port.delete();
        log_word.delete();
        log_cyc.delete();
    endtask

    task automatic wait_log(input int n, input int bound);
        int k = 0;
        while (log_port.size() < n && k < bound) begin
            tick();
            k++;
        end
        checks++;
        if (log_port.size() < n) begin
            errors++;
            $display("FAIL wait_issue: saw %0d issues, required %0d within %0d cycles", log_port.size(), n, bound);
        end
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        tick();
        while (!(wq0.size() == 0 && wq1.size() == 0 && grant == 2'b00 &&
                 !lcd_busy && !busy_active) && k < bound) begin
            tick();
            k++;
        end
        checks++;
        if (k >= bound) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles (grant=%b q0=%0d q1=%0d), required idle",
                     bound, grant, wq0.size(), wq1.size());
        end
        tick();
    endtask

    task automatic do_reset();
        int k = 0;
        while (busy_active && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (busy_active) begin
            errors++;
            $display("FAIL reset_wait: lcd model still busy, required idle");
        end
        internal_reset = 1'b1;
        wq0.delete(); lq0.delete();
        wq1.delete(); lq1.delete();
        lcd_silent = 1'b0;
        rand_lcd   = 1'b0;
        tick();
        tick();
        internal_reset = 1'b0;
        tick();
        clear_log();
    endtask

    task automatic test_reset();
        internal_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== 2'b00 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: grant=%b timeout_err=%b, required 00 0", grant, timeout_err);
        end
        checks++;
        if (lcd_d_in !== 9'h000 || lcd_data_ready !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: d_in=%h dr=%b ack=%b%b, required 000 0 00",
                     lcd_d_in, lcd_data_ready, bus.ack0, bus.ack1);
        end
        internal_reset = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int f;
        int k = 0;
        do_reset();
        rise_d   = 3;
        busy_len = 4;
        wq0.push_back(9'h038); lq0.push_back(1'b1);
        wait_log(1, 20);
        if (log_port.size() >= 1) begin
            checks++;
            if (log_cyc[0] !== pres0 + 1) begin
                errors++;
                $display("FAIL single_latency: issue at cycle %0d, required %0d", log_cyc[0], pres0 + 1);
            end
            checks++;
            if (log_word[0] !== 9'h038 || log_port[0] !== 0) begin
                errors++;
                $display("FAIL single_word: port %0d word %h, required port 0 word 038", log_port[0], log_word[0]);
            end
        end
        while ((busy_active || fall_count == 0) && k < 50) begin
            tick();
            k++;
        end
        f = fall_cyc;
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL single_grant_busy: grant=%b on busy fall cycle, required 01", grant);
        end
        at_cycle(f + 1);
        checks++;
        if (grant !== 2'b00 || lcd_d_in !== 9'h038) begin
            errors++;
            $display("FAIL single_release: grant=%b d_in=%h, required 00 038", grant, lcd_d_in);
        end
        // rr_ptr now favours port 1
        tick();
        clear_log();
        wq0.push_back(9'h001); lq0.push_back(1'b1);
        wq1.push_back(9'h1A5); lq1.push_back(1'b1);
        wait_idle(200);
        checks++;
        if (log_port.size() != 2 || log_port[0] !== 1 || log_word[0] !== 9'h1A5) begin
            errors++;
            $display("FAIL single_rr_after: first issue port %0d word %h (n=%0d), required port 1 word 1a5 (n=2)",
                     log_port.size() > 0 ? log_port[0] : -1, log_port.size() > 0 ? log_word[0] : 9'h000, log_port.size());
        end
    endtask

    task automatic test_round_robin();
        int        ep[3] = '{0, 1, 0};
        lcd_word_t ew[3] = '{9'h038, 9'h141, 9'h00C};
        do_reset();
        rise_d   = 2;
        busy_len = 3;
        wq0.push_back(9'h038); lq0.push_back(1'b1);
        wq0.push_back(9'h00C); lq0.push_back(1'b1);
        wq1.push_back(9'h141); lq1.push_back(1'b1);
        wait_idle(300);
        checks++;
        if (log_port.size() != 3) begin
            errors++;
            $display("FAIL rr_count: issued %0d words, required 3", log_port.size());
        end
        for (int i = 0; i < 3 && i < log_port.size(); i++) begin
            checks++;
            if (log_port[i] !== ep[i] || log_word[i] !== ew[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: port %0d word %h, required port %0d word %h",
                         i, log_port[i], log_word[i], ep[i], ew[i]);
            end
        end
    endtask

    task automatic test_burst_lock();
        int        ep[4] = '{1, 1, 1, 0};
        lcd_word_t ew[4] = '{9'h080, 9'h131, 9'h132, 9'h006};
        do_reset();
        rise_d   = 2;
        busy_len = 2;
        wq1.push_back(9'h080); lq1.push_back(1'b0);
        wq1.push_back(9'h131); lq1.push_back(1'b0);
        wq1.push_back(9'h132); lq1.push_back(1'b1);
        wait_log(1, 20);
        wq0.push_back(9'h006); lq0.push_back(1'b1);
        wait_idle(300);
        checks++;
        if (log_port.size() != 4) begin
            errors++;
            $display("FAIL burst_count: issued %0d words, required 4", log_port.size());
        end
        for (int i = 0; i < 4 && i < log_port.size(); i++) begin
            checks++;
            if (log_port[i] !== ep[i] || log_word[i] !== ew[i]) begin
                errors++;
                $display("FAIL burst_order[%0d]: port %0d word %h, required port %0d word %h",
                         i, log_port[i], log_word[i], ep[i], ew[i]);
            end
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL burst_no_timeout: timeout_err=%b, required 0", timeout_err);
        end
    endtask

    task automatic test_busy_timeout();
        int s;
        do_reset();
        lcd_silent = 1'b1;
        wq0.push_back(9'h028); lq0.push_back(1'b1);
        wait_log(1, 20);
        s = (log_cyc.size() > 0) ? log_cyc[0] : cyc;
        at_cycle(s + BUSY_MAX);
        checks++;
        if (timeout_err !== 1'b0 || grant !== 2'b01) begin
            errors++;
            $display("FAIL busy_timeout_early: timeout_err=%b grant=%b, required 0 01", timeout_err, grant);
        end
        at_cycle(s + BUSY_MAX + 1);
        checks++;
        if (timeout_err !== 1'b1 || grant !== 2'b00) begin
            errors++;
            $display("FAIL busy_timeout: timeout_err=%b grant=%b, required 1 00", timeout_err, grant);
        end
        lcd_silent = 1'b0;
        rise_d     = 2;
        busy_len   = 2;
        wq1.push_back(9'h0FF); lq1.push_back(1'b1);
        wait_idle(200);
        checks++;
        if (log_port.size() != 2 || log_word[log_word.size() - 1] !== 9'h0FF) begin
            errors++;
            $display("FAIL busy_timeout_recover: issued %0d words, required 2 ending with 0ff", log_port.size());
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL busy_timeout_sticky: timeout_err=%b, required 1", timeout_err);
        end
    endtask

    task automatic test_lock_timeout();
        int f;
        int old;
        int k = 0;
        do_reset();
        rise_d   = 2;
        busy_len = 3;
        old = fall_count;
        wq1.push_back(9'h155); lq1.push_back(1'b0);
        wait_log(1, 20);
        wq0.push_back(9'h0A0); lq0.push_back(1'b1);
        while (fall_count == old && k < 50) begin
            tick();
            k++;
        end
        f = fall_cyc;
        at_cycle(f + LOCK_MAX);
        checks++;
        if (timeout_err !== 1'b0 || grant !== 2'b10) begin
            errors++;
            $display("FAIL lock_timeout_early: timeout_err=%b grant=%b, required 0 10", timeout_err, grant);
        end
        at_cycle(f + LOCK_MAX + 1);
        checks++;
        if (timeout_err !== 1'b1 || grant !== 2'b00) begin
            errors++;
            $display("FAIL lock_timeout: timeout_err=%b grant=%b, required 1 00", timeout_err, grant);
        end
        wait_log(2, 10);
        if (log_port.size() >= 2) begin
            checks++;
            if (log_port[1] !== 0 || log_word[1] !== 9'h0A0 || log_cyc[1] !== f + LOCK_MAX + 2) begin
                errors++;
                $display("FAIL lock_next_owner: port %0d word %h cycle %0d, required port 0 word 0a0 cycle %0d",
                         log_port[1], log_word[1], log_cyc[1], f + LOCK_MAX + 2);
            end
        end
        wait_idle(200);
    endtask

    task automatic test_reset_mid();
        int k = 0;
        do_reset();
        rise_d   = 2;
        busy_len = 6;
        wq1.push_back(9'h1C3); lq1.push_back(1'b1);
        while (!lcd_busy && k < 30) begin
            tick();
            k++;
        end
        tick();
        internal_reset = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b00 || timeout_err !== 1'b0 || lcd_d_in !== 9'h000) begin
            errors++;
            $display("FAIL reset_mid_state: grant=%b timeout_err=%b d_in=%h, required 00 0 000",
                     grant, timeout_err, lcd_d_in);
        end
        checks++;
        if (lcd_data_ready !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_strobe: dr=%b ack=%b%b, required 0 00", lcd_data_ready, bus.ack0, bus.ack1);
        end
        tick();
        internal_reset = 1'b0;
        tick();
        clear_log();
        wq0.push_back(9'h047); lq0.push_back(1'b1);
        wq1.push_back(9'h1C4); lq1.push_back(1'b1);
        wait_idle(300);
        checks++;
        if (log_port.size() != 2 || log_port[0] !== 0 || log_word[0] !== 9'h047 ||
            log_port[1] !== 1 || log_word[1] !== 9'h1C4) begin
            errors++;
            $display("FAIL reset_mid_rr: issued %0d words, first port %0d, required 2 words, port 0 (047) then port 1 (1c4)",
                     log_port.size(), log_port.size() > 0 ? log_port[0] : -1);
        end
    endtask

    // Burst-level reference: whole queues present at once, port 0 favoured
    // after reset, and the favoured port flips to the other side after each
    // completed burst whenever both still have work.
    task automatic test_random_bursts();
        for (int it = 0; it < 4; it++) begin
            lcd_word_t w0[$];
            lcd_word_t w1[$];
            bit        l0[$];
            bit        l1[$];
            int        exp_port[$];
            lcd_word_t exp_word[$];
            int        nb;
            int        len;
            int        i0 = 0;
            int        i1 = 0;
            int        ptr = 0;
            int        p;

            do_reset();
            rand_lcd = 1'b1;
            for (int port = 0; port < 2; port++) begin
                nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(1, 3);
                    for (int w = 0; w < len; w++) begin
                        if (port == 0) begin
                            w0.push_back(lcd_word_t'($urandom_range(0, 511)));
                            l0.push_back(w == len - 1);
                        end else begin
                            w1.push_back(lcd_word_t'($urandom_range(0, 511)));
                            l1.push_back(w == len - 1);
                        end
                    end
                end
            end

            while (i0 < w0.size() || i1 < w1.size()) begin
                if (i0 < w0.size() && i1 < w1.size()) p = ptr;
                else p = (i0 < w0.size()) ? 0 : 1;
                if (p == 0) begin
                    do begin
                        exp_port.push_back(0); exp_word.push_back(w0[i0]); i0++;
                    end while (!l0[i0 - 1]);
                end else begin
                    do begin
                        exp_port.push_back(1); exp_word.push_back(w1[i1]); i1++;
                    end while (!l1[i1 - 1]);
                end
                ptr = 1 - p;
            end

            wq0 = w0; lq0 = l0;
            wq1 = w1; lq1 = l1;
            wait_idle(2000);

            checks++;
            if (log_port.size() != exp_port.size()) begin
                errors++;
                $display("FAIL rand_count[%0d]: issued %0d words, required %0d", it, log_port.size(), exp_port.size());
            end
            for (int i = 0; i < exp_port.size() && i < log_port.size(); i++) begin
                checks++;
                if (log_port[i] !== exp_port[i] || log_word[i] !== exp_word[i]) begin
                    errors++;
                    $display("FAIL rand_order[%0d.%0d]: port %0d word %h, required port %0d word %h",
                             it, i, log_port[i], log_word[i], exp_port[i], exp_word[i]);
                end
            end
            checks++;
            if (timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL rand_no_timeout[%0d]: timeout_err=%b, required 0", it, timeout_err);
            end
        end
        rand_lcd = 1'b0;
    endtask

    initial begin
        internal_reset = 1'b1;
        test_reset();
        test_single_word();
        test_round_robin();
        test_burst_lock();
        test_busy_timeout();
        test_lock_timeout();
        test_reset_mid();
        test_random_bursts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
